// File: rtl/timer_pkg.sv
// Purpose: shared constants and helpers for the machine timer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: word addresses of the four 32-bit timer registers, the mtimecmp
// reset value, and a helper that replaces one 32-bit half of a 64-bit word.
package timer_pkg;

  localparam logic [1:0] ADDR_MTIME_LO    = 2'd0;
  localparam logic [1:0] ADDR_MTIME_HI    = 2'd1;
  localparam logic [1:0] ADDR_MTIMECMP_LO = 2'd2;
  localparam logic [1:0] ADDR_MTIMECMP_HI = 2'd3;

  // All ones keeps the interrupt quiet until software programs a deadline.
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace the addressed half of cur with wd and keep the other half.
  function automatic logic [63:0] merge_half(input logic [63:0] cur,
                                             input logic [31:0] wd,
                                             input logic        hi);
    return hi ? {wd, cur[31:0]} : {cur[63:32], wd};
  endfunction

endpackage

// File: rtl/machine_timer_if.sv
// Purpose: 32-bit load/store access port of the machine timer.
// Latency: read data and rvalid are registered, one cycle after the request.
// Backpressure: none, every request is accepted in the cycle it is presented.
// Signals: req/we/addr/wd driven by the core (master), rd/rvalid by the timer (slave).
interface machine_timer_if;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rvalid;

  modport master (output req, output we, output addr, output wd,
                  input  rd,  input  rvalid);
  modport slave  (input  req, input  we, input  addr, input  wd,
                  output rd,  output rvalid);
endinterface

// File: rtl/counter.sv
// Purpose: loadable up-counter that wraps at its full width.
// Latency: load or increment visible after the clock edge.
// Backpressure: none; a load takes priority over a coincident increment.
// Ports: clk, reset (sync, active high, clears to 0), enable, we, wd in; q out.
module counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= wd;
    end else if (enable) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/register.sv
// Purpose: generic enabled register with a parameterised reset value.
// Latency: d captured at the clock edge where en is high, visible after it.
// Backpressure: none.
// Ports: clk, reset (sync, active high), en, d in; q out.
module register #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// Purpose: RISC-V machine timer (64-bit mtime/mtimecmp, level irq, prescaler).
// Latency: writes take effect at the accepting edge; read data one cycle later; irq lags state by one cycle.
// Backpressure: none, the bus port accepts every request.
// Ports: clk, reset (sync, active high), tick_en (prescaler advance),
// bus (machine_timer_if.slave: req/we/addr/wd in, rd/rvalid out), irq out.
module machine_timer #(
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  machine_timer_if.slave   bus,
  output logic             irq
);
  import timer_pkg::*;

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_cnt;
  logic          ps_wrap;
  logic          rd_acc;
  logic          wr_acc;
  logic          mtime_wr;
  logic          cmp_wr;
  logic          snap_en;
  logic [63:0]   mtime;
  logic [63:0]   mtime_wd;
  logic [63:0]   mtimecmp;
  logic [63:0]   mtimecmp_d;
  logic [31:0]   hi_snap;
  logic [31:0]   rd_d;
  logic [31:0]   rd_q;
  logic          rvalid_q;

  assign rd_acc   = bus.req & ~bus.we;
  assign wr_acc   = bus.req &  bus.we;
  assign mtime_wr = wr_acc & ((bus.addr == ADDR_MTIME_LO) | (bus.addr == ADDR_MTIME_HI));
  assign cmp_wr   = wr_acc & ((bus.addr == ADDR_MTIMECMP_LO) | (bus.addr == ADDR_MTIMECMP_HI));
  assign snap_en  = rd_acc & (bus.addr == ADDR_MTIME_LO);

  // With PRESCALE = 1 the count is pinned at 0 == PS_LAST, so every enabled
  // cycle is a wrap.
  assign ps_wrap = tick_en & (ps_cnt == PS_LAST);

  // A software write to mtime restarts the prescaler so the new value gets a
  // full tick period before its first increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (mtime_wr) begin
      ps_cnt <= '0;
    end else if (tick_en) begin
      ps_cnt <= ps_wrap ? '0 : ps_cnt + PW'(1);
    end
  end

  // Half-word writes are merged with the live other half; the counter's
  // load priority makes the write win over a coincident increment.
  assign mtime_wd = merge_half(mtime, bus.wd, bus.addr == ADDR_MTIME_HI);

  counter #(.WIDTH(64)) u_mtime (
    .clk    (clk),
    .reset  (reset),
    .enable (ps_wrap),
    .we     (mtime_wr),
    .wd     (mtime_wd),
    .q      (mtime)
  );

  assign mtimecmp_d = merge_half(mtimecmp, bus.wd, bus.addr == ADDR_MTIMECMP_HI);

  register #(.WIDTH(64), .RESET_VAL(MTIMECMP_RESET)) u_mtimecmp (
    .clk   (clk),
    .reset (reset),
    .en    (cmp_wr),
    .d     (mtimecmp_d),
    .q     (mtimecmp)
  );

  // Reading mtime_lo freezes the high half taken from the same pre-increment
  // value, so a following mtime_hi read pairs with it even across a carry.
  register #(.WIDTH(32)) u_hi_snap (
    .clk   (clk),
    .reset (reset),
    .en    (snap_en),
    .d     (mtime[63:32]),
    .q     (hi_snap)
  );

  always_comb begin
    rd_d = '0;
    case (bus.addr)
      ADDR_MTIME_LO:    rd_d = mtime[31:0];
      ADDR_MTIME_HI:    rd_d = hi_snap;
      ADDR_MTIMECMP_LO: rd_d = mtimecmp[31:0];
      ADDR_MTIMECMP_HI: rd_d = mtimecmp[63:32];
      default:          rd_d = '0;
    endcase
  end

  // rd only loads on a read so it holds its last value between reads.
  register #(.WIDTH(32)) u_rd (
    .clk   (clk),
    .reset (reset),
    .en    (rd_acc),
    .d     (rd_d),
    .q     (rd_q)
  );

  register #(.WIDTH(1)) u_rvalid (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (rd_acc),
    .q     (rvalid_q)
  );

  register #(.WIDTH(1)) u_irq (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (mtime >= mtimecmp),
    .q     (irq)
  );

  assign bus.rd     = rd_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_machine_timer.sv
// Purpose: self-checking bench for machine_timer at PRESCALE 1, 2 and 4.
// Latency: n/a.
// Backpressure: n/a.
// All three instances see the same stimulus; a behavioural model tracks each.
module tb_machine_timer;
  import timer_pkg::*;

  localparam int PS[3] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_en;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;

  logic [31:0] rd_o [3];
  logic        rv_o [3];
  logic        irq_o[3];

  int npass = 0;
  int ntot  = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  machine_timer_if b0 ();
  machine_timer_if b1 ();
  machine_timer_if b2 ();

  assign b0.req = req; assign b0.we = we; assign b0.addr = addr; assign b0.wd = wd;
  assign b1.req = req; assign b1.we = we; assign b1.addr = addr; assign b1.wd = wd;
  assign b2.req = req; assign b2.we = we; assign b2.addr = addr; assign b2.wd = wd;

  assign rd_o[0] = b0.rd; assign rv_o[0] = b0.rvalid;
  assign rd_o[1] = b1.rd; assign rv_o[1] = b1.rvalid;
  assign rd_o[2] = b2.rd; assign rv_o[2] = b2.rvalid;

  machine_timer #(.PRESCALE(1)) u_ps1 (.clk(clk), .reset(reset), .tick_en(tick_en), .bus(b0), .irq(irq_o[0]));
  machine_timer #(.PRESCALE(2)) u_ps2 (.clk(clk), .reset(reset), .tick_en(tick_en), .bus(b1), .irq(irq_o[1]));
  machine_timer #(.PRESCALE(4)) u_ps4 (.clk(clk), .reset(reset), .tick_en(tick_en), .bus(b2), .irq(irq_o[2]));

  // ---------------- reference model ----------------
  logic [63:0] m_mt  [3];
  logic [63:0] m_cmp [3];
  logic [31:0] m_snap[3];
  logic [31:0] m_rd  [3];
  logic        m_rv  [3];
  logic        m_irq [3];
  int          m_ticks[3];  // enabled cycles since the last increment or mtime write

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_mt[i] = 64'd0; m_cmp[i] = MTIMECMP_RESET; m_snap[i] = 32'd0;
        m_rd[i] = 32'd0; m_rv[i] = 1'b0; m_irq[i] = 1'b0; m_ticks[i] = 0;
      end else begin
        m_irq[i] = (m_mt[i] >= m_cmp[i]);
        m_rv[i]  = req && !we;
        if (req && !we) begin
          case (addr)
            2'd0: begin m_rd[i] = m_mt[i][31:0]; m_snap[i] = m_mt[i][63:32]; end
            2'd1: m_rd[i] = m_snap[i];
            2'd2: m_rd[i] = m_cmp[i][31:0];
            default: m_rd[i] = m_cmp[i][63:32];
          endcase
        end
        if (req && we && addr < 2'd2) begin
          if (addr == 2'd0) m_mt[i][31:0] = wd; else m_mt[i][63:32] = wd;
          m_ticks[i] = 0;
        end else begin
          if (req && we) begin
            if (addr == 2'd2) m_cmp[i][31:0] = wd; else m_cmp[i][63:32] = wd;
          end
          if (tick_en) begin
            m_ticks[i] = m_ticks[i] + 1;
            if (m_ticks[i] == PS[i]) begin
              m_ticks[i] = 0;
              m_mt[i] = m_mt[i] + 64'd1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_rvalid_ps%0d", PS[i]), {63'd0, rv_o[i]}, {63'd0, m_rv[i]});
        chk($sformatf("model_irq_ps%0d", PS[i]), {63'd0, irq_o[i]}, {63'd0, m_irq[i]});
        chk($sformatf("model_rd_ps%0d", PS[i]), {32'd0, rd_o[i]}, {32'd0, m_rd[i]});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge: drive inputs, advance one posedge, return at next negedge.
  task automatic cyc(input logic rq, input logic w, input logic [1:0] a,
                     input logic [31:0] d, input logic te);
    req = rq; we = w; addr = a; wd = d; tick_en = te;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic te);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 2'd0, 32'd0, te);
  endtask

  task automatic rd_chk(input string nm, input int i, input logic [1:0] a,
                        input logic te, input logic [31:0] exp);
    cyc(1'b1, 1'b0, a, 32'd0, te);
    chk({nm, "_rvalid"}, {63'd0, rv_o[i]}, 64'd1);
    chk(nm, {32'd0, rd_o[i]}, {32'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Directed table applied to the PRESCALE=1 instance with tick_en low.
    tbl[0]  = '{1'b0, ADDR_MTIMECMP_LO, 32'd0, 32'hFFFF_FFFF};
    tbl[1]  = '{1'b0, ADDR_MTIMECMP_HI, 32'd0, 32'hFFFF_FFFF};
    tbl[2]  = '{1'b0, ADDR_MTIME_LO,    32'd0, 32'd0};
    tbl[3]  = '{1'b0, ADDR_MTIME_HI,    32'd0, 32'd0};
    tbl[4]  = '{1'b1, ADDR_MTIMECMP_LO, 32'd5, 32'd0};
    tbl[5]  = '{1'b0, ADDR_MTIMECMP_LO, 32'd0, 32'd5};
    tbl[6]  = '{1'b1, ADDR_MTIME_HI,    32'd7, 32'd0};
    tbl[7]  = '{1'b0, ADDR_MTIME_HI,    32'd0, 32'd0};  // snapshot still old
    tbl[8]  = '{1'b0, ADDR_MTIME_LO,    32'd0, 32'd0};
    tbl[9]  = '{1'b0, ADDR_MTIME_HI,    32'd0, 32'd7};
    tbl[10] = '{1'b1, ADDR_MTIMECMP_HI, 32'd0, 32'd0};
    tbl[11] = '{1'b0, ADDR_MTIMECMP_HI, 32'd0, 32'd0};

    reset = 1'b1; tick_en = 1'b0; req = 1'b0; we = 1'b0; addr = 2'd0; wd = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_irq", {63'd0, irq_o[i]}, 64'd0);
      chk("reset_rvalid", {63'd0, rv_o[i]}, 64'd0);
      chk("reset_rd", {32'd0, rd_o[i]}, 64'd0);
    end

    for (int t = 0; t < 12; t++) begin
      if (tbl[t].w) begin
        cyc(1'b1, 1'b1, tbl[t].a, tbl[t].d, 1'b0);
        chk($sformatf("tbl%0d_wr_rvalid", t), {63'd0, rv_o[0]}, 64'd0);
      end else begin
        rd_chk($sformatf("tbl%0d_rd", t), 0, tbl[t].a, 1'b0, tbl[t].exp);
      end
    end

    // Prescaler 4: 12 enabled cycles give 3 increments; disabled cycles freeze it.
    do_reset();
    idle(12, 1'b1);
    rd_chk("ps4_after12", 2, ADDR_MTIME_LO, 1'b0, 32'd3);
    idle(10, 1'b0);
    rd_chk("ps4_frozen", 2, ADDR_MTIME_LO, 1'b0, 32'd3);

    // Carry from low to high half.
    cyc(1'b1, 1'b1, ADDR_MTIME_LO, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b1, 1'b1, ADDR_MTIME_HI, 32'd0, 1'b0);
    idle(1, 1'b1);
    rd_chk("carry_lo", 0, ADDR_MTIME_LO, 1'b0, 32'd0);
    rd_chk("carry_hi", 0, ADDR_MTIME_HI, 1'b0, 32'd1);

    // Tear-free: the lo read and its snapshot both precede the carry.
    cyc(1'b1, 1'b1, ADDR_MTIME_LO, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b1, 1'b1, ADDR_MTIME_HI, 32'd0, 1'b0);
    rd_chk("tear_lo", 0, ADDR_MTIME_LO, 1'b1, 32'hFFFF_FFFF);
    rd_chk("tear_hi", 0, ADDR_MTIME_HI, 1'b1, 32'd0);
    rd_chk("tear_lo2", 0, ADDR_MTIME_LO, 1'b0, 32'd1);
    rd_chk("tear_hi2", 0, ADDR_MTIME_HI, 1'b0, 32'd1);

    // Interrupt: mtime reaches 10 after edge 10, irq follows after edge 11.
    do_reset();
    cyc(1'b1, 1'b1, ADDR_MTIMECMP_HI, 32'd0, 1'b0);
    cyc(1'b1, 1'b1, ADDR_MTIMECMP_LO, 32'd10, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
      chk($sformatf("irq_rise_n%0d", n), {63'd0, irq_o[0]}, (n >= 11) ? 64'd1 : 64'd0);
    end
    cyc(1'b1, 1'b1, ADDR_MTIMECMP_HI, 32'd1, 1'b1);
    chk("irq_hold_on_cmp_write", {63'd0, irq_o[0]}, 64'd1);
    idle(1, 1'b0);
    chk("irq_fall", {63'd0, irq_o[0]}, 64'd0);

    // Write on a prescaler-wrap cycle (PRESCALE=2): write wins, prescaler restarts.
    do_reset();
    idle(3, 1'b1);
    cyc(1'b1, 1'b1, ADDR_MTIME_LO, 32'h100, 1'b1);
    rd_chk("coll_wr", 1, ADDR_MTIME_LO, 1'b0, 32'h100);
    idle(1, 1'b1);
    rd_chk("coll_one_tick", 1, ADDR_MTIME_LO, 1'b0, 32'h100);
    idle(1, 1'b1);
    rd_chk("coll_two_ticks", 1, ADDR_MTIME_LO, 1'b0, 32'h101);

    // Reset mid-count with irq high and a read pending.
    cyc(1'b1, 1'b1, ADDR_MTIMECMP_LO, 32'd0, 1'b1);
    cyc(1'b1, 1'b1, ADDR_MTIMECMP_HI, 32'd0, 1'b1);
    idle(4, 1'b1);
    cyc(1'b1, 1'b0, ADDR_MTIME_LO, 32'd0, 1'b1);
    reset = 1'b1;
    cyc(1'b1, 1'b0, ADDR_MTIME_LO, 32'd0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_irq%0d", i), {63'd0, irq_o[i]}, 64'd0);
      chk($sformatf("midrst_rvalid%0d", i), {63'd0, rv_o[i]}, 64'd0);
      chk($sformatf("midrst_rd%0d", i), {32'd0, rd_o[i]}, 64'd0);
    end
    rd_chk("midrst_mtime", 2, ADDR_MTIME_LO, 1'b0, 32'd0);
    rd_chk("midrst_cmp_hi", 1, ADDR_MTIMECMP_HI, 1'b0, 32'hFFFF_FFFF);

    // Randomised traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] d;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      d = $urandom;
      else if (sel == 1) d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else               d = $urandom_range(0, 64);
      reset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) < 2,
          2'($urandom_range(0, 3)), d, $urandom_range(0, 9) < 7);
    end
    reset = 1'b0;
    idle(2, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer: a 64-bit `mtime` counter and a 64-bit `mtimecmp` register, both accessed as 32-bit halves by the core's load/store path. The timer raises a level timer-interrupt request to the CSR/trap logic when `mtime >= mtimecmp`. A 32-bit side reads `mtime` tear-free through a latched high-half snapshot. A configurable prescaler divides the increment rate.

## Interface
Parameters:
- `PRESCALE`, default 1: number of enabled clock cycles per `mtime` increment; legal range 1..65535.

Ports:
- `clk`  input  1: clock; all state changes on the rising edge.
- `reset`  input  1: synchronous, active-high.
- `tick_en`  input  1: prescaler advances on cycles where this is high.
- `req`  input  1: bus access valid this cycle.
- `we`  input  1: 1 = write, 0 = read; ignored when `req` = 0.
- `addr`  input  2: word select. 0 = `mtime_lo`, 1 = `mtime_hi`, 2 = `mtimecmp_lo`, 3 = `mtimecmp_hi`.
- `wd`  input  32: write data.
- `rd`  output  32: read data; valid when `rvalid` = 1.
- `rvalid`  output  1: one-cycle pulse, the cycle after an accepted read.
- `irq`  output  1: timer interrupt request, registered, level.

## Operation
- Reset values:
  - `mtime` = 0, `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF.
  - Prescaler count = 0, `hi_snap` = 0.
  - `rd` = 0, `rvalid` = 0, `irq` = 0.
- Prescaler count width is `$clog2(PRESCALE)`, minimum 1 bit.
  - When `tick_en` = 1: if count == `PRESCALE`-1, the count wraps to 0 and `mtime` increments; otherwise the count increments.
  - When `PRESCALE` = 1, `mtime` increments on every enabled cycle.
- `mtime` increments as a full 64-bit value: carry propagates from the low half into the high half. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes:
  - To `mtime_lo` or `mtime_hi`: replace only that half, clear the prescaler to 0, and suppress any increment that cycle. The write wins over a coincident increment.
  - To `mtimecmp` halves: replace only the addressed half.
- Reads:
  - `mtime_lo` returns the current low half and copies the current high half into `hi_snap`, in the same edge.
  - `mtime_hi` returns `hi_snap`, never the live high half.
  - `mtimecmp` halves return their live values.
- No access has any side effect when `req` = 0.
- Comparison is an unsigned 64-bit compare. `irq` next = (`mtime` >= `mtimecmp`), evaluated on current register values.
- No FSM beyond the prescaler. The block always accepts; there is no backpressure.

## Timing
- Read accepted at edge k: `rd`/`rvalid` are valid after edge k+1. `rvalid` is low on every cycle with no read. `rd` holds its last value when `rvalid` = 0.
- Write accepted at edge k: the register is updated at edge k. A read accepted at edge k+1 returns the new value.
- `irq` lags register state by one cycle. Example: `mtimecmp` written at edge k; `irq` reflects the comparison at edge k+1.
- Reset asserted mid-operation: all state returns to reset values at the next edge. Any pending `rvalid` is dropped.
- Simultaneous read of `mtime_lo` and an increment in the same cycle:
  - Returned low value and snapshot are both pre-increment values from the same cycle.
  - This keeps the lo/hi pair consistent.

## Structure
- Shared package `timer_pkg`:
  - Address constants `ADDR_MTIME_LO`, `ADDR_MTIME_HI`, `ADDR_MTIMECMP_LO`, `ADDR_MTIMECMP_HI`.
  - `MTIMECMP_RESET` = all ones.
- Natural sub-module: the team's `counter` (WIDTH 64) for `mtime`.
  - `enable` driven by prescaler wrap.
  - `we`/`wd` driven by a merged half-write: the unaddressed half is fed back.
- `mtimecmp`, `hi_snap`, `rd`, `rvalid` and `irq` use the team's `register` module.

## Test plan
- Reset, then read addr 2 and 3 → 0xFFFF_FFFF each; read addr 0 and 1 → 0; `irq` = 0 throughout.
- `PRESCALE` = 4, `tick_en` high for 12 cycles from reset → read `mtime_lo` = 3; with `tick_en` low for 10 more cycles → still 3.
- Write `mtime_lo` = 0xFFFF_FFFF and `mtime_hi` = 0, one increment, read lo then hi → 0x0000_0000 then 0x0000_0001.
- Tear-free read:
  - Setup: `mtime` = 0x0000_0000_FFFF_FFFF, `PRESCALE` = 1, `tick_en` = 1.
  - Stimulus: read lo, then read hi on the next cycle.
  - Required response: lo = 0xFFFF_FFFF and hi = 0x0000_0000, even though the live high half is already 1.
- Interrupt:
  - Write `mtimecmp_hi` = 0 and `mtimecmp_lo` = 10, then count up.
  - `irq` rises exactly one cycle after `mtime` reaches 10.
  - Write `mtimecmp_hi` = 1 → `irq` falls one cycle later.
- Write/increment collision:
  - Write `mtime_lo` = 0x100 on a prescaler-wrap cycle with `PRESCALE` = 2 → `mtime_lo` = 0x100, not 0x101.
  - The next increment occurs 2 enabled cycles later.
  - Assert `reset` mid-count → all reset values on the next cycle.
